trivium_stream_core: RTL and testbench

- Parametrised Trivium stream-cipher engine producing W keystream bits per clock.
- Loads an 80-bit key and 80-bit IV, runs the 1152-round warm-up, then XORs keystream onto a ready/valid data stream (encrypt and decrypt are the same operation).
- Enforces a per-key word budget and requires a rekey when it is used up.
- Sits between the host data FIFO and the link serializer.

---
 rtl/trivium_stream_core.sv | 149 ++++++++++++++
 tb/tb_trivium_stream_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_stream_core.sv
// rtl/trivium_stream_core.sv - Trivium keystream engine XORing W bits per clock onto a ready/valid stream
module trivium_stream_core #(
    parameter int               W         = 8,
    parameter int               CNT_W     = 33,
    parameter logic [CNT_W-1:0] MAX_WORDS = CNT_W'(64'h1_0000_0000)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [79:0]  key,
    input  logic [79:0]  iv,
    input  logic         start,
    output logic         ready_key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         exhausted
);

    localparam int               INIT_CYCLES = 1152 / W;
    localparam int               IC_W        = 11;
    localparam logic [IC_W-1:0]  INIT_LAST   = IC_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_WORD   = MAX_WORDS - 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        EXH
    } state_t;

    state_t state, state_next;

    // s[i] holds Trivium bit s(i+1)
    logic [287:0]     s;
    logic [287:0]     s_adv;
    logic [287:0]     image;
    logic [W-1:0]     z;
    logic [IC_W-1:0]  init_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             load;
    logic             advance;
    logic             accept;

    // key in s1..s80, iv in s94..s173, ones in s286..s288, zeros elsewhere
    assign image = {3'b111, 108'b0, 4'b0, iv, 13'b0, key};

    assign ready_key = (state == RUN);
    assign exhausted = (state == EXH);
    assign cnt_inc   = (cnt == MAX_WORDS) ? cnt : cnt + 1'b1;

    // W chained rounds; round j supplies keystream bit j
    always_comb begin
        logic t1, t2, t3;
        s_adv = s;
        z     = '0;
        for (int j = 0; j < W; j++) begin
            t1   = s_adv[65] ^ s_adv[92];
            t2   = s_adv[161] ^ s_adv[176];
            t3   = s_adv[242] ^ s_adv[287];
            z[j] = t1 ^ t2 ^ t3;
            t1   = t1 ^ (s_adv[90] & s_adv[91]) ^ s_adv[170];
            t2   = t2 ^ (s_adv[174] & s_adv[175]) ^ s_adv[263];
            t3   = t3 ^ (s_adv[285] & s_adv[286]) ^ s_adv[68];
            s_adv = {s_adv[286:177], t2, s_adv[175:93], t1, s_adv[91:0], t3};
        end
    end

    // next state and handshake decode; start overrides everything
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        if (start) begin
            load       = 1'b1;
            state_next = INIT;
        end else begin
            case (state)
                INIT: begin
                    advance = 1'b1;
                    if (init_cnt == INIT_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    in_ready = !out_valid || out_ready;
                    accept   = in_valid && in_ready;
                    advance  = accept;
                    if (accept && (cnt == LAST_WORD)) begin
                        state_next = EXH;
                    end
                end
                default: ;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cipher state, counters and the single output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s         <= '0;
            init_cnt  <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (load) begin
                s        <= image;
                init_cnt <= '0;
                cnt      <= '0;
            end else begin
                if (advance) begin
                    s <= s_adv;
                end
                if (state == INIT) begin
                    init_cnt <= init_cnt + 1'b1;
                end
                if (accept) begin
                    cnt <= cnt_inc;
                end
            end

            // abort drops a pending word; a word left over from exhaustion still drains
            if (load && (state == INIT || state == RUN)) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data ^ z;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_core.sv
// tb/tb_trivium_stream_core.sv - directed bench for trivium_stream_core against a bit-serial Trivium model
module tb_trivium_stream_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [79:0] key = '0;
    logic [79:0] iv  = '0;

    logic        st8 = 1'b0, ival8 = 1'b0, ordy8 = 1'b0;
    logic [7:0]  idat8 = '0;
    logic        rk8, ird8, oval8, ex8;
    logic [7:0]  odat8;

    logic        stx = 1'b0, ivalx = 1'b0, ordyx = 1'b0;
    logic [7:0]  idatx = '0;
    logic        rkx, irdx, ovalx, exx;
    logic [7:0]  odatx;

    logic        st64 = 1'b0, ival64 = 1'b0, ordy64 = 1'b0;
    logic [63:0] idat64 = '0;
    logic        rk64, ird64, oval64, ex64;
    logic [63:0] odat64;

    int nvec;
    int nfail;

    bit ms [1:288];

    logic [7:0] pt [0:99];
    logic [7:0] ct [0:99];

    localparam logic [79:0] K1  = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] V1  = 80'h3210FEDCBA9876543210;
    localparam logic [79:0] V2  = 80'h00000000000000000001;

    always #5 clk = ~clk;

    trivium_stream_core #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .key(key), .iv(iv), .start(st8), .ready_key(rk8),
        .in_valid(ival8), .in_ready(ird8), .in_data(idat8),
        .out_valid(oval8), .out_ready(ordy8), .out_data(odat8), .exhausted(ex8)
    );

    trivium_stream_core #(.W(8), .CNT_W(33), .MAX_WORDS(33'd4)) dutx (
        .clk(clk), .rst(rst), .key(key), .iv(iv), .start(stx), .ready_key(rkx),
        .in_valid(ivalx), .in_ready(irdx), .in_data(idatx),
        .out_valid(ovalx), .out_ready(ordyx), .out_data(odatx), .exhausted(exx)
    );

    trivium_stream_core #(.W(64)) dut64 (
        .clk(clk), .rst(rst), .key(key), .iv(iv), .start(st64), .ready_key(rk64),
        .in_valid(ival64), .in_ready(ird64), .in_data(idat64),
        .out_valid(oval64), .out_ready(ordy64), .out_data(odat64), .exhausted(ex64)
    );

    function automatic bit mround();
        bit t1, t2, t3, zz;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        zz = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 288; i > 1; i--) ms[i] = ms[i-1];
        ms[1]   = t3;
        ms[94]  = t1;
        ms[178] = t2;
        return zz;
    endfunction

    task automatic mload(input logic [79:0] k, input logic [79:0] v);
        bit dummy;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ms[i+1]  = k[i];
            ms[94+i] = v[i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        for (int i = 0; i < 1152; i++) dummy = mround();
    endtask

    function automatic logic [63:0] mword(input int n);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < n; j++) w[j] = mround();
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // one accepted word on instance which (0=dut8, 1=dutx, 2=dut64), checked against the model
    task automatic word(input int which, input logic [63:0] d, input string tag, output logic [63:0] got);
        logic [63:0] ks, exp, mask, ov, od, ir;
        int n;
        n    = (which == 2) ? 64 : 8;
        mask = (which == 2) ? {64{1'b1}} : 64'hff;
        case (which)
            0: begin ival8 = 1'b1; idat8 = d[7:0]; ordy8 = 1'b1; #0 ir = 64'(ird8); end
            1: begin ivalx = 1'b1; idatx = d[7:0]; ordyx = 1'b1; #0 ir = 64'(irdx); end
            default: begin ival64 = 1'b1; idat64 = d; ordy64 = 1'b1; #0 ir = 64'(ird64); end
        endcase
        check({tag, "_in_ready"}, ir, 64'd1);
        tick();
        ks  = mword(n);
        exp = (d ^ ks) & mask;
        case (which)
            0: begin ov = 64'(oval8); od = 64'(odat8); ival8 = 1'b0; end
            1: begin ov = 64'(ovalx); od = 64'(odatx); ivalx = 1'b0; end
            default: begin ov = 64'(oval64); od = odat64; ival64 = 1'b0; end
        endcase
        check({tag, "_out_valid"}, ov, 64'd1);
        check({tag, "_out_data"}, od, exp);
        got = od;
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] held;
        nvec  = 0;
        nfail = 0;

        #12;
        check("rst_ready_key", 64'(rk8), 64'd0);
        check("rst_out_valid", 64'(oval8), 64'd0);
        check("rst_out_data", 64'(odat8), 64'd0);
        check("rst_exhausted", 64'(ex8), 64'd0);
        ival8 = 1'b1;
        #1;
        check("idle_in_ready", 64'(ird8), 64'd0);
        ival8 = 1'b0;
        rst   = 1'b1;
        tick();

        key = '0;
        iv  = '0;
        st8 = 1'b1;
        tick();
        st8 = 1'b0;
        repeat (143) tick();
        check("w8_init_143", 64'(rk8), 64'd0);
        tick();
        check("w8_init_144", 64'(rk8), 64'd1);

        mload('0, '0);
        for (int k = 0; k < 16; k++) word(0, 64'd0, "ks0", got);
        ordy8 = 1'b1;
        tick();
        check("drain_out_valid", 64'(oval8), 64'd0);

        word(0, 64'h5a, "bp_a", held);
        ordy8 = 1'b0;
        ival8 = 1'b1;
        idat8 = 8'hc3;
        for (int c = 0; c < 5; c++) begin
            #0;
            check("bp_in_ready", 64'(ird8), 64'd0);
            tick();
            check("bp_out_valid", 64'(oval8), 64'd1);
            check("bp_out_data", 64'(odat8), held);
        end
        ival8 = 1'b0;
        word(0, 64'hc3, "bp_resume", got);
        word(0, 64'h11, "bp_next", got);

        key   = K1;
        iv    = V1;
        st8   = 1'b1;
        ival8 = 1'b1;
        #0;
        check("start_blocks_in_ready", 64'(ird8), 64'd0);
        tick();
        st8   = 1'b0;
        ival8 = 1'b0;
        repeat (144) tick();
        check("enc_ready_key", 64'(rk8), 64'd1);
        mload(K1, V1);
        for (int i = 0; i < 100; i++) begin
            pt[i] = 8'($urandom);
            word(0, 64'(pt[i]), "enc", got);
            ct[i] = got[7:0];
        end

        st8 = 1'b1;
        tick();
        st8 = 1'b0;
        repeat (144) tick();
        mload(K1, V1);
        for (int i = 0; i < 100; i++) begin
            word(0, 64'(ct[i]), "dec", got);
            check("dec_plain", got, 64'(pt[i]));
        end

        st8 = 1'b1;
        tick();
        st8 = 1'b0;
        repeat (144) tick();
        mload(K1, V1);
        for (int i = 0; i < 3; i++) word(0, 64'(i), "pre_abort", got);
        ordy8 = 1'b0;
        ival8 = 1'b1;
        idat8 = 8'h00;
        iv    = V2;
        st8   = 1'b1;
        #0;
        check("abort_in_ready", 64'(ird8), 64'd0);
        tick();
        st8   = 1'b0;
        ival8 = 1'b0;
        check("abort_out_valid", 64'(oval8), 64'd0);
        check("abort_ready_key", 64'(rk8), 64'd0);
        repeat (143) tick();
        check("reinit_143", 64'(rk8), 64'd0);
        tick();
        check("reinit_144", 64'(rk8), 64'd1);
        mload(K1, V2);
        for (int i = 0; i < 4; i++) word(0, 64'(8'h30 + i), "new_iv", got);

        key = '0;
        iv  = '0;
        stx = 1'b1;
        tick();
        stx = 1'b0;
        repeat (144) tick();
        check("x_ready_key", 64'(rkx), 64'd1);
        mload('0, '0);
        for (int i = 0; i < 3; i++) word(1, 64'(8'ha0 + i), "x_pre", got);
        check("x_not_exhausted_3", 64'(exx), 64'd0);
        word(1, 64'h7e, "x_last", got);
        ivalx = 1'b1;
        #0;
        check("x_exhausted", 64'(exx), 64'd1);
        check("x_in_ready_blocked", 64'(irdx), 64'd0);
        check("x_ready_key_low", 64'(rkx), 64'd0);
        check("x_last_pending", 64'(ovalx), 64'd1);
        ivalx = 1'b0;
        tick();
        check("x_last_drained", 64'(ovalx), 64'd0);
        stx = 1'b1;
        tick();
        stx = 1'b0;
        check("x_exhausted_cleared", 64'(exx), 64'd0);
        repeat (143) tick();
        check("x_reinit_143", 64'(rkx), 64'd0);
        tick();
        check("x_reinit_144", 64'(rkx), 64'd1);
        mload('0, '0);
        for (int i = 0; i < 3; i++) word(1, 64'(8'h10 + i), "x_again", got);
        check("x_counter_cleared", 64'(exx), 64'd0);
        word(1, 64'h44, "x_again_last", got);
        check("x_exhausted_again", 64'(exx), 64'd1);

        st64 = 1'b1;
        tick();
        st64 = 1'b0;
        repeat (17) tick();
        check("w64_init_17", 64'(rk64), 64'd0);
        tick();
        check("w64_init_18", 64'(rk64), 64'd1);
        mload('0, '0);
        word(2, 64'd0, "w64_ks", got);
        word(2, {$urandom, $urandom}, "w64_data", got);

        ordy8 = 1'b0;
        ival8 = 1'b1;
        idat8 = 8'hff;
        stx   = 1'b1;
        tick();
        stx   = 1'b0;
        ival8 = 1'b0;
        check("pre_rst_out_valid", 64'(oval8), 64'd1);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(oval8), 64'd0);
        check("arst_out_data", 64'(odat8), 64'd0);
        check("arst_ready_key", 64'(rk8), 64'd0);
        check("arst_w64_ready_key", 64'(rk64), 64'd0);
        check("arst_w64_out_data", odat64, 64'd0);
        check("arst_x_exhausted", 64'(exx), 64'd0);
        rst = 1'b1;
        repeat (150) tick();
        check("post_rst_x_idle", 64'(rkx), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
